mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, the only clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have CPU write port: m_write  in  1  write request; m_inaddr  in  14  write address; m_indata  in  10  write data.
REQ-003 SHALL have CPU read ports N=1..4: m_readN  in  1  read request; m_outaddrN  in  14  read address; m_outdataN  out  10  registered read data.
REQ-004 SHALL have stall  out  1  CPU hold; while high the CPU does not take a clock edge and keeps its requests stable.
REQ-005 SHALL have RAM side: ram_addr  out  14; ram_we  out  1; ram_wdata  out  10; ram_rdata  in  10, synchronous single-port RAM, read data valid the cycle after address issue.
REQ-006 SHALL have debug outputs: D_MSTATE  out  2  current state; D_PEND  out  5  pending mask {write, read4..read1}.

Function
REQ-007 SHALL implement states IDLE (00), RUN (01), DONE (10); encoding 11 SHALL go to IDLE.
REQ-008 In IDLE, stall SHALL equal the OR of m_write and m_read1..4, combinationally in the same cycle.
REQ-009 In IDLE with any request, SHALL latch the request mask, all five addresses and m_indata, then go to RUN.
REQ-010 In RUN, stall SHALL be 1; in DONE, stall SHALL be 0.
REQ-011 Each RUN cycle with reads pending SHALL issue the lowest-numbered pending read: ram_addr = its latched address, ram_we = 0, and clear its pending bit.
REQ-012 The cycle after a read issue, SHALL load ram_rdata into that port's m_outdataN register; capture and the next issue SHALL overlap (one read per cycle).
REQ-013 Write SHALL issue only after all reads are issued: ram_we = 1 for exactly one cycle, with ram_addr = latched write address and ram_wdata = latched data.
REQ-014 The write SHALL share a cycle with the final read capture when both apply.
REQ-015 Reads SHALL return pre-write data when a read and the write target the same address in one request.
REQ-016 Duplicate read addresses SHALL each be serviced and captured separately.
REQ-017 RUN SHALL exit to DONE after the cycle in which no reads are pending, no capture is outstanding and no write is pending.
REQ-018 Stall-high cycles per request SHALL be n+2 for n reads (n=1..4, write optional) and 2 for a write only.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE; requests SHALL be ignored in DONE.
REQ-020 m_outdataN SHALL hold its value until that port is next captured; ports not requested SHALL keep their old data.
REQ-021 ram_we SHALL be 0 in every cycle except the write-issue cycle; ram_addr and ram_wdata SHALL be don't-care when idle.
REQ-022 Request inputs SHALL be ignored in RUN; the latched copy is authoritative.

Reset
REQ-023 While rst is high: state = IDLE, pending mask = 0, stall = 0, ram_we = 0, all m_outdataN = 0.
REQ-024 rst during RUN SHALL abort the operation, suppress any pending write and leave m_outdataN = 0 after the reset edge.
REQ-025 After rst deasserts, the first IDLE cycle SHALL evaluate requests normally.

Verification
REQ-026 RAM[0x2000..0x2002] = 0x011, 0x022, 0x033; read1/2/3 at 0x2000/0x2001/0x2002 -> stall high 5 cycles, then m_outdata1..3 = 0x011/0x022/0x033 in the DONE cycle with stall 0.
REQ-027 Write-only request m_write = 1, address 0x0005, data 0x3FF -> stall high 2 cycles, ram_we pulses once, a later read of 0x0005 returns 0x3FF.
REQ-028 read4 and write both at 0x0010 (old 0x0AA, new 0x155) -> m_outdata4 = 0x0AA, RAM[0x0010] = 0x155, stall high 3 cycles.
REQ-029 All four reads plus a write -> stall high 6 cycles, issue order 1,2,3,4, write in the 6th cycle together with capture of read4.
REQ-030 rst asserted in the 2nd RUN cycle of a 4-read + write request -> no ram_we pulse, stall 0, all m_outdataN = 0, D_MSTATE = 00.
REQ-031 Back-to-back requests held continuously -> DONE cycle with stall 0 between them, and the second request restarts from IDLE.

Source files
------------

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Sequences one CPU request (up to four reads plus one write) onto a
// synchronous single-port RAM. The request is latched in IDLE. Reads are
// issued one per cycle, lowest port number first. The write goes out last, so
// every read in a request sees the RAM contents from before that request's
// write. The CPU is held off with 'stall' until the operation completes.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   m_write/m_inaddr/
//   m_indata               : CPU write request, address, data
//   m_readN/m_outaddrN     : CPU read request N=1..4 and its address
//   m_outdataN             : registered read data for port N
//   stall                  : CPU hold (combinational in IDLE)
//   ram_addr/ram_we/
//   ram_wdata/ram_rdata    : RAM side; rdata is valid one cycle after address
//   D_MSTATE, D_PEND       : debug: current state, pending {write, read4..1}
// -----------------------------------------------------------------------------
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_write,
    input  logic [13:0] m_inaddr,
    input  logic [9:0]  m_indata,
    input  logic        m_read1,
    input  logic [13:0] m_outaddr1,
    output logic [9:0]  m_outdata1,
    input  logic        m_read2,
    input  logic [13:0] m_outaddr2,
    output logic [9:0]  m_outdata2,
    input  logic        m_read3,
    input  logic [13:0] m_outaddr3,
    output logic [9:0]  m_outdata3,
    input  logic        m_read4,
    input  logic [13:0] m_outaddr4,
    output logic [9:0]  m_outdata4,
    output logic        stall,
    output logic [13:0] ram_addr,
    output logic        ram_we,
    output logic [9:0]  ram_wdata,
    input  logic [9:0]  ram_rdata,
    output logic [1:0]  D_MSTATE,
    output logic [4:0]  D_PEND
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      r_state;
    logic [4:0]  r_pend;       // {write, read4, read3, read2, read1}
    logic [13:0] r_addr1;
    logic [13:0] r_addr2;
    logic [13:0] r_addr3;
    logic [13:0] r_addr4;
    logic [13:0] r_waddr;
    logic [9:0]  r_wdata;
    logic        r_cap_vld;    // a read was issued last cycle; rdata is valid now
    logic [1:0]  r_cap_port;   // which port that read belongs to
    logic [9:0]  r_out1;
    logic [9:0]  r_out2;
    logic [9:0]  r_out3;
    logic [9:0]  r_out4;

    logic        w_any_req;
    logic        w_rd_pend;
    logic [1:0]  w_rd_sel;
    logic [13:0] w_rd_addr;

    assign w_any_req  = m_write | m_read1 | m_read2 | m_read3 | m_read4;
    assign w_rd_pend  = |r_pend[3:0];
    assign m_outdata1 = r_out1;
    assign m_outdata2 = r_out2;
    assign m_outdata3 = r_out3;
    assign m_outdata4 = r_out4;
    assign ram_wdata  = r_wdata;
    assign D_MSTATE   = r_state;
    assign D_PEND     = r_pend;

    // Pick the lowest-numbered pending read and its latched address.
    always_comb begin
        w_rd_sel  = 2'd0;
        w_rd_addr = r_addr1;
        if (r_pend[0]) begin
            w_rd_sel  = 2'd0;
            w_rd_addr = r_addr1;
        end else if (r_pend[1]) begin
            w_rd_sel  = 2'd1;
            w_rd_addr = r_addr2;
        end else if (r_pend[2]) begin
            w_rd_sel  = 2'd2;
            w_rd_addr = r_addr3;
        end else if (r_pend[3]) begin
            w_rd_sel  = 2'd3;
            w_rd_addr = r_addr4;
        end else begin
            w_rd_sel  = 2'd0;
            w_rd_addr = r_addr1;
        end
    end

    // CPU hold and RAM command. stall must react to a new request in the same
    // IDLE cycle, so it is decoded from state rather than registered. Reset
    // forces every command inactive at once.
    always_comb begin
        stall    = 1'b0;
        ram_we   = 1'b0;
        ram_addr = 14'd0;
        if (rst) begin
            stall    = 1'b0;
            ram_we   = 1'b0;
            ram_addr = 14'd0;
        end else begin
            case (r_state)
                ST_IDLE: stall = w_any_req;
                ST_RUN: begin
                    stall = 1'b1;
                    if (w_rd_pend) begin
                        ram_addr = w_rd_addr;
                    end else if (r_pend[4]) begin
                        // Write only once every read has gone out; this is what
                        // gives reads the pre-write data for a shared address.
                        ram_we   = 1'b1;
                        ram_addr = r_waddr;
                    end else begin
                        ram_addr = 14'd0;
                    end
                end
                ST_DONE: stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end
    end

    // Request latch, issue sequencing and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pend     <= 5'd0;
            r_addr1    <= 14'd0;
            r_addr2    <= 14'd0;
            r_addr3    <= 14'd0;
            r_addr4    <= 14'd0;
            r_waddr    <= 14'd0;
            r_wdata    <= 10'd0;
            r_cap_vld  <= 1'b0;
            r_cap_port <= 2'd0;
            r_out1     <= 10'd0;
            r_out2     <= 10'd0;
            r_out3     <= 10'd0;
            r_out4     <= 10'd0;
        end else begin
            // Capture of the read issued last cycle overlaps the next issue.
            if (r_cap_vld) begin
                case (r_cap_port)
                    2'd0:    r_out1 <= ram_rdata;
                    2'd1:    r_out2 <= ram_rdata;
                    2'd2:    r_out3 <= ram_rdata;
                    2'd3:    r_out4 <= ram_rdata;
                    default: r_out1 <= ram_rdata;
                endcase
            end else begin
                r_out1 <= r_out1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cap_vld <= 1'b0;
                    if (w_any_req) begin
                        r_pend  <= {m_write, m_read4, m_read3, m_read2, m_read1};
                        r_addr1 <= m_outaddr1;
                        r_addr2 <= m_outaddr2;
                        r_addr3 <= m_outaddr3;
                        r_addr4 <= m_outaddr4;
                        r_waddr <= m_inaddr;
                        r_wdata <= m_indata;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_rd_pend) begin
                        r_pend     <= r_pend & ~(5'b00001 << w_rd_sel);
                        r_cap_vld  <= 1'b1;
                        r_cap_port <= w_rd_sel;
                    end else begin
                        // No read left to issue: this cycle finishes the last
                        // capture and/or the write, so the operation ends here.
                        r_pend    <= 5'd0;
                        r_cap_vld <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_cap_vld <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    // Unused encoding 2'b11 recovers to IDLE.
                    r_pend    <= 5'd0;
                    r_cap_vld <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Randomized scoreboard bench for mem_ctrl. A behavioural RAM sits on the RAM
// port. For each request the driver computes the expected outcome from a
// reference memory: stall length, the RAM command sequence, the write data and
// the m_outdata values. It pushes that outcome into a queue. A monitor
// records each operation and compares it when the DONE cycle appears.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        m_write;
    logic [13:0] m_inaddr;
    logic [9:0]  m_indata;
    logic        m_read1, m_read2, m_read3, m_read4;
    logic [13:0] m_outaddr1, m_outaddr2, m_outaddr3, m_outaddr4;
    logic [9:0]  m_outdata1, m_outdata2, m_outdata3, m_outdata4;
    logic        stall;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [9:0]  ram_wdata;
    logic [9:0]  ram_rdata;
    logic [1:0]  D_MSTATE;
    logic [4:0]  D_PEND;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
        .m_read1(m_read1), .m_outaddr1(m_outaddr1), .m_outdata1(m_outdata1),
        .m_read2(m_read2), .m_outaddr2(m_outaddr2), .m_outdata2(m_outdata2),
        .m_read3(m_read3), .m_outaddr3(m_outaddr3), .m_outdata3(m_outdata3),
        .m_read4(m_read4), .m_outaddr4(m_outaddr4), .m_outdata4(m_outdata4),
        .stall(stall),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .D_MSTATE(D_MSTATE), .D_PEND(D_PEND)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM with read-before-write, plus a preload port.
    logic [9:0]  tb_mem [16384];
    logic        pl_en;
    logic [13:0] pl_addr;
    logic [9:0]  pl_data;
    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_addr] <= pl_data;
        else if (ram_we) tb_mem[ram_addr] <= ram_wdata;
        ram_rdata <= tb_mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        bit              abort;
        int              stall_cyc;
        int              nrun;
        int              nwr;
        logic [5:0][14:0] seq;   // {we, addr} expected for each RUN cycle
        logic [5:0]      dc;     // slot whose address is don't-care (we must be 0)
        logic [9:0]      wd;
        logic [3:0][9:0] od;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    logic [9:0]       ref_mem [logic [13:0]];
    logic [3:0][9:0]  ref_od;

    // Current request.
    logic             q_w;
    logic [3:0]       q_rm;
    logic [4:0][13:0] q_a;    // [0..3] read addresses, [4] write address
    logic [9:0]       q_d;

    // Expected result of a request: reads see memory before this request's
    // write, they are serviced in port order, the write goes last, and
    // stall lasts (number of reads + 2) cycles.
    task automatic push_expect();
        exp_t e;
        int n;
        e = '0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (q_rm[i]) begin
                e.seq[n]  = {1'b0, q_a[i]};
                ref_od[i] = ref_mem[q_a[i]];
                n++;
            end
        end
        if (q_w) begin
            e.seq[n]       = {1'b1, q_a[4]};
            e.wd           = q_d;
            e.nwr          = 1;
            ref_mem[q_a[4]] = q_d;
        end else begin
            e.dc[n] = 1'b1;
            e.nwr   = 0;
        end
        e.nrun      = n + 1;
        e.stall_cyc = n + 2;
        e.od        = ref_od;
        sb.push_back(e);
    endtask

    task automatic apply_inputs();
        m_write = q_w;      m_inaddr = q_a[4];  m_indata = q_d;
        m_read1 = q_rm[0];  m_outaddr1 = q_a[0];
        m_read2 = q_rm[1];  m_outaddr2 = q_a[1];
        m_read3 = q_rm[2];  m_outaddr3 = q_a[2];
        m_read4 = q_rm[3];  m_outaddr4 = q_a[3];
    endtask

    task automatic clear_inputs();
        m_write = 1'b0; m_inaddr = 14'd0; m_indata = 10'd0;
        m_read1 = 1'b0; m_read2 = 1'b0; m_read3 = 1'b0; m_read4 = 1'b0;
        m_outaddr1 = 14'd0; m_outaddr2 = 14'd0; m_outaddr3 = 14'd0; m_outaddr4 = 14'd0;
    endtask

    task automatic scramble_inputs();
        m_write = 1'($urandom);     m_inaddr = 14'($urandom);  m_indata = 10'($urandom);
        m_read1 = 1'($urandom);     m_read2 = 1'($urandom);
        m_read3 = 1'($urandom);     m_read4 = 1'($urandom);
        m_outaddr1 = 14'($urandom); m_outaddr2 = 14'($urandom);
        m_outaddr3 = 14'($urandom); m_outaddr4 = 14'($urandom);
    endtask

    // Issue the current request in IDLE, hold it (or garble it while RUN) and
    // return at the edge leaving DONE.
    task automatic run_req(input bit scramble);
        bit got;
        push_expect();
        apply_inputs();
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (D_MSTATE == 2'b10) begin
                got = 1'b1;
                break;
            end
            if (scramble && D_MSTATE == 2'b01) scramble_inputs();
        end
        chk("reached_done", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input bit narrow);
        q_w  = 1'($urandom);
        q_rm = 4'($urandom);
        if (!q_w && q_rm == 4'd0) q_rm = 4'($urandom_range(1, 15));
        for (int i = 0; i < 5; i++)
            q_a[i] = narrow ? 14'($urandom_range(0, 3)) : 14'($urandom_range(0, 63));
        q_d = 10'($urandom);
    endtask

    // Monitor: collects one operation and scores it in its DONE cycle.
    int                mon_st;
    int                mon_run;
    int                mon_we;
    bit                mon_busy = 1'b0;
    logic [7:0][14:0]  mon_seq;
    logic [9:0]        mon_wd;
    exp_t              mon_e;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_we", 32'(ram_we), 32'd0);
            if (mon_busy) begin
                chk("abort_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("abort_flag", 32'(mon_e.abort), 32'd1);
                    chk("abort_no_we", 32'(mon_we), 32'd0);
                end
            end
            mon_busy = 1'b0;
            mon_st = 0; mon_run = 0; mon_we = 0;
        end else begin
            if (D_MSTATE == 2'b00)
                chk("idle_stall", 32'(stall),
                    32'(m_write | m_read1 | m_read2 | m_read3 | m_read4));
            if (D_MSTATE != 2'b01)
                chk("we_outside_run", 32'(ram_we), 32'd0);
            if (stall) begin
                mon_st++;
                mon_busy = 1'b1;
            end
            if (D_MSTATE == 2'b01) begin
                if (mon_run < 8) mon_seq[mon_run] = {ram_we, ram_addr};
                if (ram_we) begin
                    mon_we++;
                    mon_wd = ram_wdata;
                end
                mon_run++;
            end
            if (D_MSTATE == 2'b10) begin
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_pend", 32'(D_PEND), 32'd0);
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("stall_cycles", 32'(mon_st), 32'(mon_e.stall_cyc));
                    chk("run_cycles", 32'(mon_run), 32'(mon_e.nrun));
                    for (int i = 0; i < mon_e.nrun && i < 6; i++) begin
                        if (mon_e.dc[i]) chk("run_we_low", 32'(mon_seq[i][14]), 32'd0);
                        else             chk("run_slot", 32'(mon_seq[i]), 32'(mon_e.seq[i]));
                    end
                    chk("we_pulses", 32'(mon_we), 32'(mon_e.nwr));
                    if (mon_e.nwr == 1) chk("wdata", 32'(mon_wd), 32'(mon_e.wd));
                    chk("outdata1", 32'(m_outdata1), 32'(mon_e.od[0]));
                    chk("outdata2", 32'(m_outdata2), 32'(mon_e.od[1]));
                    chk("outdata3", 32'(m_outdata3), 32'(mon_e.od[2]));
                    chk("outdata4", 32'(m_outdata4), 32'(mon_e.od[3]));
                end
                mon_busy = 1'b0;
                mon_st = 0; mon_run = 0; mon_we = 0;
            end
        end
    end

    task automatic preload(input logic [13:0] a, input logic [9:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        pl_en = 1'b0; pl_addr = 14'd0; pl_data = 10'd0;
        ref_od = '0;
        clear_inputs();
        for (int a = 0; a < 64; a++) preload(14'(a), 10'($urandom));
        preload(14'h2000, 10'h011);
        preload(14'h2001, 10'h022);
        preload(14'h2002, 10'h033);
        preload(14'h0010, 10'h0AA);

        // Reset state.
        @(negedge clk);
        chk("reset_state", 32'(D_MSTATE), 32'd0);
        chk("reset_pend", 32'(D_PEND), 32'd0);
        chk("reset_out", 32'({m_outdata1, m_outdata2, m_outdata3, m_outdata4}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Three reads from the 0x2000 block.
        q_w = 1'b0; q_rm = 4'b0111; q_d = 10'd0;
        q_a = '0; q_a[0] = 14'h2000; q_a[1] = 14'h2001; q_a[2] = 14'h2002;
        run_req(1'b0);

        // Write-only, then read it back.
        q_w = 1'b1; q_rm = 4'b0000; q_a = '0; q_a[4] = 14'h0005; q_d = 10'h3FF;
        run_req(1'b0);
        q_w = 1'b0; q_rm = 4'b0001; q_a = '0; q_a[0] = 14'h0005;
        run_req(1'b0);

        // Read and write on the same address: read must see the old value.
        q_w = 1'b1; q_rm = 4'b1000; q_a = '0; q_a[3] = 14'h0010; q_a[4] = 14'h0010; q_d = 10'h155;
        run_req(1'b0);
        q_w = 1'b0; q_rm = 4'b0010; q_a = '0; q_a[1] = 14'h0010;
        run_req(1'b0);

        // All four reads plus a write, inputs garbled while RUN.
        q_w = 1'b1; q_rm = 4'b1111; q_d = 10'($urandom);
        for (int i = 0; i < 5; i++) q_a[i] = 14'($urandom_range(0, 63));
        run_req(1'b1);

        // Reset in the second RUN cycle of a 4-read + write request. The
        // write targets read1's address with fresh data so a leaked write
        // would show up when the request is replayed.
        q_w = 1'b1; q_rm = 4'b1111;
        for (int i = 0; i < 4; i++) q_a[i] = 14'($urandom_range(0, 63));
        q_a[4] = q_a[0];
        q_d = ~ref_mem[q_a[0]];
        e = '0;
        e.abort = 1'b1;
        sb.push_back(e);
        apply_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_state", 32'(D_MSTATE), 32'd0);
        chk("abort_pend", 32'(D_PEND), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_out", 32'({m_outdata1, m_outdata2, m_outdata3, m_outdata4}), 32'd0);
        ref_od = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        // Request is still held; the first IDLE cycle must take it.
        run_req(1'b0);

        // Random traffic, mostly back-to-back, sometimes with idle gaps.
        for (int t = 0; t < 80; t++) begin
            rand_req(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                clear_inputs();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_req(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end

        clear_inputs();
        repeat (4) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
